dbus_dma: RTL
=============

Name: dbus_dma

Overview:
- Bus initiator (master) for the 16-bit data bus. It copies a block of words from a source address to a destination address using the same single-cycle-address / one-cycle-read-latency protocol the CPU uses.
- Sits beside the CPU in front of the dbus address decoder. An external arbiter muxes CPU vs DMA onto din/addr/we using bus_req/bus_gnt.
- Frees the CPU from word-by-word RAM/IO copy loops.

Parameters:
- DW, 16, bus data width.
- AW, 16, bus address width.
- LEN_W, 13, width of transfer length (max 8191 words per start).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle pulse; latches src/dst/len when idle
- src  in  AW  first source word address
- dst  in  AW  first destination word address
- len  in  LEN_W  number of words to copy
- busy  out  1  high from accepted start until completion
- done  out  1  one-cycle pulse on completion
- remain  out  LEN_W  words still to copy
- bus_req  out  1  request bus ownership
- bus_gnt  in  1  arbiter grant
- m_addr  out  AW  bus address
- m_wdata  out  DW  bus write data (to decoder din)
- m_we  out  1  bus write enable, active high
- m_rdata  in  DW  bus read data (decoder dout), valid the cycle after its address

Behaviour:
- Reset rst: synchronous, active-high; clock clk. All outputs are 0 after the reset edge; the FSM goes to IDLE. Reset mid-transfer aborts with no done pulse, and m_we is 0 from the next cycle.
- FSM states: IDLE, REQ, RD, WR, FIN. State and counters are registered. m_addr/m_we/m_wdata decode from the current state.
- IDLE:
  - start=1 latches sa<=src, da<=dst, cnt<=len.
  - len=0 goes to FIN (no bus cycle, bus_req stays 0).
  - Otherwise goes to REQ. busy=1 from the next cycle.
  - start while busy is ignored.
- REQ:
  - bus_req=1, m_we=0, m_addr=0.
  - bus_gnt=1 goes to RD; otherwise stays in REQ.
- RD:
  - bus_req=1, m_addr=sa, m_we=0. Always goes to WR.
- WR:
  - bus_req=1, m_addr=da, m_we=1, m_wdata=m_rdata (combinational pass-through of the read issued in RD).
  - At the edge: sa+1, da+1, cnt-1.
  - If cnt==1, goes to FIN. Otherwise goes to RD, or to REQ under the optional feature.
- FIN: done=1 for one cycle, bus_req=0, busy=0 from the next cycle. Returns to IDLE.
- Throughput: 2 cycles per word once granted. A len=N transfer with a pre-asserted grant takes 1+1+2N+1 cycles from start to done.
- Arbiter contract:
  - bus_gnt is sampled only in REQ.
  - The arbiter must hold bus_gnt while bus_req=1. The engine never re-checks grant mid-word.
- Address arithmetic is modulo 2^AW: 16'hFFFF+1 wraps to 0.
- Overlap is not detected. The copy is strictly forward (ascending addresses).
- Values:
  - remain=cnt.
  - m_addr=0, m_wdata=0, m_we=0 in IDLE/REQ/FIN.
  - m_wdata=0 in RD.

Optional Feature:
- Macro DMA_YIELD_EN.
- Defined: after each WR with cnt>1, go to REQ instead of RD. bus_req drops to 0 for that REQ cycle's first cycle, and the engine re-requests. This gives the arbiter a slot to hand the bus to the CPU between words. Throughput is at least 3 cycles/word.
- Undefined: back-to-back RD/WR, and bus_req stays high for the whole transfer.

Decomposition:
- Shared package (dbus_pkg) holds:
  - DW/AW constants
  - block-select width (3 MSBs)
  - FSM state encoding localparams
  - the bus timing constant RD_LAT=1
- No sub-module is natural. Single module: FSM plus three registers (sa, da, cnt). Roughly 150 lines.

Test Plan:
- src=0x0010, dst=0x0040, len=4, gnt tied 1, RAM[0x10..0x13]=A1,B2,C3,D4 -> RAM[0x40..0x43]=A1,B2,C3,D4. done 11 cycles after start; remain steps 4,3,2,1,0.
- len=0 start -> done pulses 2 cycles after start; bus_req, m_we never 1; busy high for exactly 1 cycle.
- gnt held 0 for 5 cycles after start, then 1 -> engine holds REQ with m_we=0 for 5 cycles, then copies correctly. No bus cycle before grant.
- src=0xFFFE, dst=0x2000 (IO block), len=3 -> reads 0xFFFE,0xFFFF,0x0000; writes 0x2000..0x2002. The gpio_out final value equals RAM[0x0000].
- rst asserted in the WR cycle of word 2 of len=4 -> next cycle busy=0, m_we=0, bus_req=0, no done. Only word 1 is written, word 2 is written or not per that cycle's edge. A new start then runs cleanly.
- With DMA_YIELD_EN, len=3 -> bus_req low for exactly one cycle between each word. Total cycles 1+(3×3)+1 with gnt=1. Data is correct.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared definitions for the 16-bit data bus and its initiators.
// Contents: bus widths, block-select width (top address bits used by the
// decoder), the read-latency constant, and the DMA FSM state encoding.
package dbus_pkg;

  localparam int DBUS_DW = 16;
  localparam int DBUS_AW = 16;
  localparam int BLK_W   = 3;   // address MSBs that select a decoder block
  localparam int RD_LAT  = 1;   // read data valid the cycle after its address

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_REQ  = S_REQ,
    ST_RD   = S_RD,
    ST_WR   = S_WR,
    ST_FIN  = S_FIN
  } dma_state_e;

endpackage

// File: rtl/dbus_dma.sv
// dbus_dma: block-copy bus initiator for the 16-bit data bus.
// Copies len words from src.. to dst.. (ascending, modulo 2^AW) using the
// single-cycle-address / one-cycle-read-latency bus protocol. Each word is
// a RD cycle (address sa) followed by a WR cycle (address da) whose write
// data is the read data returned for the RD cycle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle pulse, accepted only when idle
//   src, dst, len   first source / destination word address, word count
//   busy, done      busy from accepted start to completion; done pulse
//   remain          words still to copy
//   bus_req/bus_gnt bus ownership request / arbiter grant (sampled in REQ)
//   m_addr, m_wdata, m_we, m_rdata   bus master signals
//
// Build option: define DMA_YIELD_EN to release the bus request for one
// cycle between words so the arbiter can slot the CPU in.
module dbus_dma
  import dbus_pkg::*;
#(
  parameter int DW    = DBUS_DW,
  parameter int AW    = DBUS_AW,
  parameter int LEN_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    src,
  input  logic [AW-1:0]    dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] remain,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [AW-1:0]    m_addr,
  output logic [DW-1:0]    m_wdata,
  output logic             m_we,
  input  logic [DW-1:0]    m_rdata
);

  dma_state_e       state;
  logic [AW-1:0]    sa;
  logic [AW-1:0]    da;
  logic [LEN_W-1:0] cnt;
  logic             yield_slot;

`ifdef DMA_YIELD_EN
  logic yield_q;   // set for the first REQ cycle after a word
  assign yield_slot = yield_q;
`else
  assign yield_slot = 1'b0;
`endif

  // Control: state and word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
`ifdef DMA_YIELD_EN
      yield_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            cnt   <= len;
            state <= (len == '0) ? ST_FIN : ST_REQ;
          end
        end
        ST_REQ: begin
`ifdef DMA_YIELD_EN
          yield_q <= 1'b0;
`endif
          if (bus_gnt) state <= ST_RD;
        end
        ST_RD: state <= ST_WR;
        ST_WR: begin
          cnt <= cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) begin
            state <= ST_FIN;
          end else begin
`ifdef DMA_YIELD_EN
            state   <= ST_REQ;
            yield_q <= 1'b1;
`else
            state <= ST_RD;
`endif
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Address registers: loaded on an accepted start, stepped after each write
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      sa <= src;
      da <= dst;
    end else if (state == ST_WR) begin
      sa <= sa + AW'(1);
      da <= da + AW'(1);
    end
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_FIN);
  assign remain  = cnt;
  assign bus_req = (state == ST_RD) || (state == ST_WR) ||
                   ((state == ST_REQ) && !yield_slot);
  assign m_we    = (state == ST_WR);
  assign m_addr  = (state == ST_RD) ? sa :
                   (state == ST_WR) ? da : '0;
  // Read data returned for the RD address is forwarded straight to the bus.
  assign m_wdata = (state == ST_WR) ? m_rdata : '0;

endmodule
